// File: rtl/demux_bin_pkg.sv
// Shared helpers for the binary-select demultiplexer tree: level count and
// configuration sanity check used at elaboration time.
package demux_bin_pkg;

   function automatic int levels(input int width, input int split);
      return $clog2(width) / $clog2(split);
   endfunction

   // True when split is a power of two (>=2) and width is split**k with k>=1.
   function automatic bit cfg_ok(input int width, input int split);
      int w;
      bit ok;
      w  = width;
      ok = (split >= 32'sd2) && ((split & (split - 32'sd1)) == 32'sd0) && (width >= split);
      while (ok && (w > 32'sd1)) begin
         if ((w % split) != 32'sd0) ok = 1'b0;
         else w = w / split;
      end
      return ok;
   endfunction

endpackage

// File: rtl/demux_bin_node.sv
// One tree node: a single registered entry that steers its item to one of
// SPLIT children using the top select bits, then hands the rest downward.
module demux_bin_node
   import demux_bin_pkg::*;
#(
   parameter type DAT_T = logic [8-1:0],
   parameter int  SPLIT = 2,
   parameter int  SEL_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [SEL_W-1:0] in_sel,
   input  DAT_T             in_dat,
   output logic [SPLIT-1:0] out_vld,
   input  logic [SPLIT-1:0] out_rdy,
   output logic [SEL_W-1:0] out_sel,
   output DAT_T             out_dat
);

   localparam int SPLIT_LOG = $clog2(SPLIT);

   logic                 vld_q, vld_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   DAT_T                 dat_q, dat_d;
   logic [SPLIT_LOG-1:0] idx_s;
   logic                 load_s;
   logic                 drain_s;

   assign idx_s   = sel_q[SEL_W-1 -: SPLIT_LOG];
   assign drain_s = vld_q && out_rdy[idx_s];
   assign in_rdy  = !vld_q || out_rdy[idx_s];
   assign load_s  = in_vld && in_rdy;

   // Next entry: a new item overwrites (covers load+drain); a lone drain empties.
   always_comb begin
      vld_d = vld_q;
      sel_d = sel_q;
      dat_d = dat_q;
      if (load_s) begin
         vld_d = 1'b1;
         sel_d = in_sel;
         dat_d = in_dat;
      end else if (drain_s) begin
         vld_d = 1'b0;
      end else begin
         vld_d = vld_q;
      end
   end

   // Entry register; payload is cleared too so outputs are defined from reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= 1'b0;
         sel_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         sel_q <= sel_d;
         dat_q <= dat_d;
      end
   end

   assign out_vld = vld_q ? ({{(SPLIT-1){1'b0}}, 1'b1} << idx_s) : '0;
   assign out_sel = sel_q << SPLIT_LOG;
   assign out_dat = dat_q;

endmodule

// File: rtl/demux_bin_tree.sv
// Pipelined binary-select demultiplexer: a SPLIT-ary tree of registered nodes,
// one stage per level, with ready flowing combinationally from leaves to root.
module demux_bin_tree
   import demux_bin_pkg::*;
#(
   parameter type DAT_T = logic [8-1:0],
   parameter int  WIDTH = 32,
   parameter int  SPLIT = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_vld,
   output logic                     i_rdy,
   input  logic [$clog2(WIDTH)-1:0] i_bin,
   input  DAT_T                     i_dat,
   output logic [WIDTH-1:0]         o_vld,
   input  logic [WIDTH-1:0]         o_rdy,
   output DAT_T                     o_dat [WIDTH-1:0]
);

   localparam int WIDTH_LOG = $clog2(WIDTH);
   localparam int LEVELS    = levels(WIDTH, SPLIT);

   if (!cfg_ok(WIDTH, SPLIT)) begin : g_bad_cfg
      $error("demux_bin_tree: WIDTH must be SPLIT**k (k>=1) with SPLIT a power of two");
   end

   for (genvar L = 0; L < LEVELS; L++) begin : g_lvl
      localparam int NL = SPLIT ** L;

      logic [NL-1:0]        in_vld;
      logic [NL-1:0]        in_rdy;
      logic [NL*SPLIT-1:0]  ch_vld;
      logic [NL*SPLIT-1:0]  ch_rdy;
      logic [WIDTH_LOG-1:0] in_sel  [NL];
      logic [WIDTH_LOG-1:0] out_sel [NL];
      DAT_T                 in_dat  [NL];
      DAT_T                 out_dat [NL];

      if (L == 0) begin : g_root
         assign in_vld    = i_vld;
         assign in_sel[0] = i_bin;
         assign in_dat[0] = i_dat;
         assign i_rdy     = in_rdy[0];
      end else begin : g_inner
         assign in_vld = g_lvl[L-1].ch_vld;
         for (genvar n = 0; n < NL; n++) begin : g_link
            assign in_sel[n] = g_lvl[L-1].out_sel[n / SPLIT];
            assign in_dat[n] = g_lvl[L-1].out_dat[n / SPLIT];
         end
      end

      // Leaf n fans its single entry out to destinations n*SPLIT .. n*SPLIT+SPLIT-1.
      if (L == LEVELS - 1) begin : g_leaf
         assign ch_rdy = o_rdy;
         assign o_vld  = ch_vld;
         for (genvar n = 0; n < NL; n++) begin : g_out
            logic sel_unused;
            assign sel_unused = ^out_sel[n];
            for (genvar i = 0; i < SPLIT; i++) begin : g_lane
               assign o_dat[n*SPLIT+i] = out_dat[n];
            end
         end
      end else begin : g_mid
         assign ch_rdy = g_lvl[L+1].in_rdy;
      end

      for (genvar n = 0; n < NL; n++) begin : g_node
         demux_bin_node #(
            .DAT_T (DAT_T),
            .SPLIT (SPLIT),
            .SEL_W (WIDTH_LOG)
         ) u_node (
            .clk     (clk),
            .rst     (rst),
            .in_vld  (in_vld[n]),
            .in_rdy  (in_rdy[n]),
            .in_sel  (in_sel[n]),
            .in_dat  (in_dat[n]),
            .out_vld (ch_vld[n*SPLIT +: SPLIT]),
            .out_rdy (ch_rdy[n*SPLIT +: SPLIT]),
            .out_sel (out_sel[n]),
            .out_dat (out_dat[n])
         );
      end
   end

endmodule

// File: tb/tb_demux_bin_tree.sv
// Directed bench for demux_bin_tree: an 8-way tree driven from a vector table,
// plus hand sequences for async reset, reset in flight and the 2-way tree.
module tb_demux_bin_tree;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       i_vld, i_rdy;
   logic [2:0] i_bin;
   logic [7:0] i_dat;
   logic [7:0] o_vld, o_rdy;
   logic [7:0] o_dat [7:0];

   logic       d_i_vld, d_i_rdy;
   logic [0:0] d_i_bin;
   logic [7:0] d_i_dat;
   logic [1:0] d_o_vld, d_o_rdy;
   logic [7:0] d_o_dat [1:0];

   int n_tests = 0;
   int n_fail  = 0;

   demux_bin_tree #(.DAT_T(logic [7:0]), .WIDTH(8), .SPLIT(2)) dut (
      .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy), .i_bin(i_bin),
      .i_dat(i_dat), .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat)
   );

   demux_bin_tree #(.DAT_T(logic [7:0]), .WIDTH(2), .SPLIT(2)) dut2 (
      .clk(clk), .rst(rst), .i_vld(d_i_vld), .i_rdy(d_i_rdy), .i_bin(d_i_bin),
      .i_dat(d_i_dat), .o_vld(d_o_vld), .o_rdy(d_o_rdy), .o_dat(d_o_dat)
   );

   // Inputs applied on the falling edge; the check then sees the state left by
   // the previous rising edge plus the combinational ready for these inputs.
   typedef struct {
      logic       vld;
      logic [2:0] bin;
      logic [7:0] dat;
      logic [7:0] rdy;
      logic       exp_irdy;
      logic [7:0] exp_ovld;
      int         lane;
      logic [7:0] exp_dat;
   } vec_t;

   vec_t vecs [$];

   function automatic void add(input logic vld, input logic [2:0] bin, input logic [7:0] dat,
                               input logic [7:0] rdy, input logic exp_irdy,
                               input logic [7:0] exp_ovld, input int lane, input logic [7:0] exp_dat);
      vec_t v;
      v.vld = vld; v.bin = bin; v.dat = dat; v.rdy = rdy;
      v.exp_irdy = exp_irdy; v.exp_ovld = exp_ovld; v.lane = lane; v.exp_dat = exp_dat;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cycles;

      // single item to 5, visible in the third sample after acceptance
      add(1'b1, 3'd5, 8'hA5, 8'hFF, 1'b1, 8'h00, 0, 8'h00);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 0, 8'h00);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 0, 8'h00);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h20, 5, 8'hA5);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 0, 8'h00);
      // back-to-back stream to every destination
      add(1'b1, 3'd0, 8'h10, 8'hFF, 1'b1, 8'h00, 0, 8'h00);
      add(1'b1, 3'd1, 8'h11, 8'hFF, 1'b1, 8'h00, 0, 8'h00);
      add(1'b1, 3'd2, 8'h12, 8'hFF, 1'b1, 8'h00, 0, 8'h00);
      add(1'b1, 3'd3, 8'h13, 8'hFF, 1'b1, 8'h01, 0, 8'h10);
      add(1'b1, 3'd4, 8'h14, 8'hFF, 1'b1, 8'h02, 1, 8'h11);
      add(1'b1, 3'd5, 8'h15, 8'hFF, 1'b1, 8'h04, 2, 8'h12);
      add(1'b1, 3'd6, 8'h16, 8'hFF, 1'b1, 8'h08, 3, 8'h13);
      add(1'b1, 3'd7, 8'h17, 8'hFF, 1'b1, 8'h10, 4, 8'h14);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h20, 5, 8'h15);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h40, 6, 8'h16);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h80, 7, 8'h17);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 0, 8'h00);
      // destination 3 stalled: 4 overtakes on the other branch, root blocks on the third 3
      add(1'b1, 3'd3, 8'h3A, 8'hF7, 1'b1, 8'h00, 0, 8'h00);
      add(1'b1, 3'd3, 8'h3B, 8'hF7, 1'b1, 8'h00, 0, 8'h00);
      add(1'b1, 3'd4, 8'h4E, 8'hF7, 1'b1, 8'h00, 0, 8'h00);
      add(1'b1, 3'd3, 8'h3C, 8'hF7, 1'b1, 8'h08, 3, 8'h3A);
      add(1'b1, 3'd3, 8'h3D, 8'hF7, 1'b0, 8'h08, 3, 8'h3A);
      add(1'b1, 3'd3, 8'h3D, 8'hF7, 1'b0, 8'h18, 4, 8'h4E);
      add(1'b1, 3'd3, 8'h3D, 8'hFF, 1'b1, 8'h08, 3, 8'h3A);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h08, 3, 8'h3B);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h08, 3, 8'h3C);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h08, 3, 8'h3D);
      add(1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 0, 8'h00);

      rst = 1'b1;
      i_vld = 1'b0; i_bin = 3'd0; i_dat = 8'h00; o_rdy = 8'hFF;
      d_i_vld = 1'b0; d_i_bin = 1'b0; d_i_dat = 8'h00; d_o_rdy = 2'b00;
      #1;
      check("reset_ovld", o_vld, 8'h00);
      check("reset_irdy", i_rdy, 1'b1);
      check("deg_reset_ovld", d_o_vld, 2'b00);
      check("deg_reset_irdy", d_i_rdy, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         i_vld = vecs[i].vld;
         i_bin = vecs[i].bin;
         i_dat = vecs[i].dat;
         o_rdy = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d_irdy", i), i_rdy, vecs[i].exp_irdy);
         check($sformatf("vec%0d_ovld", i), o_vld, vecs[i].exp_ovld);
         if (vecs[i].exp_ovld != 8'h00)
            check($sformatf("vec%0d_odat", i), o_dat[vecs[i].lane], vecs[i].exp_dat);
      end

      // two items in flight, then an asynchronous reset in the middle of a cycle
      @(negedge clk);
      i_vld = 1'b1; i_bin = 3'd2; i_dat = 8'h77;
      @(negedge clk);
      i_bin = 3'd6; i_dat = 8'h66;
      @(negedge clk);
      i_vld = 1'b0;
      @(posedge clk);
      #1;
      check("inflight_ovld", o_vld, 8'h04);
      check("inflight_odat", o_dat[2], 8'h77);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_ovld", o_vld, 8'h00);
      check("async_rst_irdy", i_rdy, 1'b1);
      for (int k = 0; k < 8; k++)
         check($sformatf("async_rst_odat%0d", k), o_dat[k], 8'h00);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("discard_ovld%0d", k), o_vld, 8'h00);
      end

      @(negedge clk);
      i_vld = 1'b1; i_bin = 3'd7; i_dat = 8'h5A;
      #1;
      check("post_rst_irdy", i_rdy, 1'b1);
      cycles = 0;
      do begin
         @(negedge clk);
         i_vld = 1'b0;
         #1;
         cycles++;
      end while ((o_vld == 8'h00) && (cycles < 10));
      check("post_rst_latency", cycles, 3);
      check("post_rst_ovld", o_vld, 8'h80);
      check("post_rst_odat", o_dat[7], 8'h5A);

      // 2-way tree: single stage, destination 1 held off
      @(negedge clk);
      d_i_vld = 1'b1; d_i_bin = 1'b1; d_i_dat = 8'h3C;
      #1;
      check("deg_irdy_empty", d_i_rdy, 1'b1);
      @(negedge clk);
      d_i_vld = 1'b0; d_i_bin = 1'b0; d_i_dat = 8'h00;
      #1;
      check("deg_ovld", d_o_vld, 2'b10);
      check("deg_odat", d_o_dat[1], 8'h3C);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("deg_hold_ovld%0d", k), d_o_vld, 2'b10);
         check($sformatf("deg_hold_odat%0d", k), d_o_dat[1], 8'h3C);
         check($sformatf("deg_hold_irdy%0d", k), d_i_rdy, 1'b0);
      end
      @(negedge clk);
      d_o_rdy = 2'b11;
      #1;
      check("deg_release_irdy", d_i_rdy, 1'b1);
      @(negedge clk);
      #1;
      check("deg_drained_ovld", d_o_vld, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
